alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational CPU ALU.
- Adds a registered flag file (ZCNV), carry-chained ADC/SBC, variable-amount shifts done one bit per cycle, and an iterative shift-add multiplier.
- Operands arrive through a valid/ready handshake; each result is returned with a one-cycle out_valid pulse.
- Sits between the register file and writeback; the control FSM stalls on in_ready.

---
 rtl/alu_mc_pkg.sv | 34 +++
 rtl/alu_mc_if.sv | 29 ++
 rtl/alu_mc_comb.sv | 58 +++++
 rtl/alu_mc.sv | 201 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and overflow helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SLLN = 4'd10;
    localparam logic [3:0] OP_SRLN = 4'd11;
    localparam logic [3:0] OP_SRAN = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow for add (is_sub=0) and subtract (is_sub=1) from the operand/result MSBs.
    function automatic logic ovf(input logic is_sub, input logic a_msb,
                                 input logic b_msb, input logic r_msb);
        if (is_sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        else
            return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the issuing control logic and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, result_hi,
        input  flag_z, flag_c, flag_n, flag_v
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, result_hi,
        output flag_z, flag_c, flag_n, flag_v
    );
endinterface

// File: rtl/alu_mc_comb.sv
// Single-cycle datapath: arithmetic, logic and 1-bit shifts with carry/overflow.
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c,
    output logic             o_v
);

    logic             w_add_cin;
    logic             w_sub_bin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;

    // Carry/borrow-in only participates for the chained variants.
    assign w_add_cin = (i_op == OP_ADC) ? i_cin : 1'b0;
    assign w_sub_bin = (i_op == OP_SBC) ? i_cin : 1'b0;
    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_sub = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, w_sub_bin};

    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC: begin
                o_result = w_add[WIDTH-1:0];
                o_c      = w_add[WIDTH];
                o_v      = ovf(1'b0, i_a[WIDTH-1], i_b[WIDTH-1], w_add[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                o_result = w_sub[WIDTH-1:0];
                o_c      = w_sub[WIDTH];
                o_v      = ovf(1'b1, i_a[WIDTH-1], i_b[WIDTH-1], w_sub[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_c      = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[WIDTH-1:1]};
                o_c      = i_a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready issue, iterative shifts and shift-add multiply, registered ZCNV flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic   clk,
    input logic   rst,
    alu_mc_if.slave bus
);

    localparam int CNTW = $clog2(WIDTH + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_in_ready;
    logic              w_out_valid;

    logic [3:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_hi;
    logic [CNTW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  r_result_hi;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_flag_n;
    logic              r_flag_v;

    logic              w_accept;
    logic [SHW-1:0]    w_amt;
    logic              w_is_shift_op;
    logic              w_multi;
    logic              w_last;
    logic              w_busy;

    logic [WIDTH-1:0]  w_comb_result;
    logic              w_comb_c;
    logic              w_comb_v;

    logic [WIDTH-1:0]  w_sh_next;
    logic              w_sh_out;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH-1:0]  w_mul_hi_next;
    logic [WIDTH-1:0]  w_mul_lo_next;

    logic              w_wr_en;
    logic [WIDTH-1:0]  w_wr_result;
    logic [WIDTH-1:0]  w_wr_hi;
    logic              w_wr_c;
    logic              w_wr_v;

    assign w_amt         = bus.b[SHW-1:0];
    assign w_is_shift_op = (bus.op == OP_SLLN) || (bus.op == OP_SRLN) || (bus.op == OP_SRAN);
    assign w_multi       = (bus.op == OP_MUL) || (w_is_shift_op && (w_amt != '0));
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_busy        = (r_state == ST_BUSY);
    assign w_last        = (r_cnt == CNTW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid)
                    w_state_next = w_multi ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (w_last)
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op     (bus.op),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_cin    (r_flag_c),
        .o_result (w_comb_result),
        .o_c      (w_comb_c),
        .o_v      (w_comb_v)
    );

    // One iteration of the captured shift or multiply.
    always_comb begin
        w_sh_next = r_a;
        w_sh_out  = 1'b0;
        case (r_op)
            OP_SLLN: begin
                w_sh_next = {r_a[WIDTH-2:0], 1'b0};
                w_sh_out  = r_a[WIDTH-1];
            end
            OP_SRLN: begin
                w_sh_next = {1'b0, r_a[WIDTH-1:1]};
                w_sh_out  = r_a[0];
            end
            OP_SRAN: begin
                w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                w_sh_out  = r_a[0];
            end
            default: ;
        endcase
    end

    // {r_hi, r_b} forms the product register; the multiplier bits drain out of r_b.
    assign w_mul_sum     = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_next = w_mul_sum[WIDTH:1];
    assign w_mul_lo_next = {w_mul_sum[0], r_b[WIDTH-1:1]};

    always_comb begin
        w_wr_en     = (w_accept && !w_multi) || (w_busy && w_last);
        w_wr_result = '0;
        w_wr_hi     = '0;
        w_wr_c      = 1'b0;
        w_wr_v      = 1'b0;
        if (w_busy) begin
            if (r_op == OP_MUL) begin
                w_wr_result = w_mul_lo_next;
                w_wr_hi     = w_mul_hi_next;
                w_wr_c      = (w_mul_hi_next != '0);
                w_wr_v      = (w_mul_hi_next != '0);
            end else begin
                w_wr_result = w_sh_next;
                w_wr_c      = w_sh_out;
            end
        end else if (w_is_shift_op) begin
            w_wr_result = bus.a;
        end else begin
            w_wr_result = w_comb_result;
            w_wr_c      = w_comb_c;
            w_wr_v      = w_comb_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_hi        <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_v    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.op;
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_hi  <= '0;
                r_cnt <= (bus.op == OP_MUL) ? CNTW'(WIDTH) : CNTW'(w_amt);
            end else if (w_busy) begin
                if (r_op == OP_MUL) begin
                    r_hi <= w_mul_hi_next;
                    r_b  <= w_mul_lo_next;
                end else begin
                    r_a  <= w_sh_next;
                end
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_wr_en) begin
                r_result    <= w_wr_result;
                r_result_hi <= w_wr_hi;
                r_flag_z    <= (w_wr_result == '0);
                r_flag_n    <= w_wr_result[WIDTH-1];
                r_flag_c    <= w_wr_c;
                r_flag_v    <= w_wr_v;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;
    assign bus.flag_n    = r_flag_n;
    assign bus.flag_v    = r_flag_v;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8: latency, result, result_hi and ZCNV flags per operation.
module tb_alu_mc;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    alu_mc_if #(.WIDTH(8)) bus ();

    alu_mc #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v};
    endfunction

    // Called at a negedge while idle; returns at a negedge with the ALU idle again.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                          input logic [7:0] exp_hi, input logic [3:0] exp_zcnv);
        int  lat;
        int  busy_lo;
        bit  seen;
        lat     = 0;
        busy_lo = 0;
        seen    = 0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'h5A;
        bus.b        = 8'hC3;
        bus.op       = 4'd0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) begin
                seen         = 1;
                bus.in_valid = 1'b0;
            end else begin
                if (!bus.in_ready)
                    busy_lo++;
                // Requests while busy must be ignored.
                bus.in_valid = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        check({tag, " timeout"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, busy_lo, exp_lat - 1);
        check({tag, " result"}, {24'd0, bus.result}, {24'd0, exp_res});
        check({tag, " result_hi"}, {24'd0, bus.result_hi}, {24'd0, exp_hi});
        check({tag, " zcnv"}, flags_now(), {28'd0, exp_zcnv});
        @(negedge clk);
        check({tag, " pulse"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        check({tag, " held"}, {24'd0, bus.result}, {24'd0, exp_res});
        $display("txn %-10s op=%0d a=%02h b=%02h -> lat=%0d res=%02h hi=%02h zcnv=%04b",
                 tag, op, a, b, lat, bus.result, bus.result_hi, flags_now());
    endtask

    initial begin
        int ov_cnt;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset result", {24'd0, bus.result}, 32'd0);
        check("reset zcnv", flags_now(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //       tag        op     a      b      lat res    hi     zcnv
        run_op("add_ovf",  4'd0,  8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'b0011);
        run_op("add_wrap", 4'd0,  8'hFF, 8'h01, 1, 8'h00, 8'h00, 4'b1100);
        run_op("adc",      4'd8,  8'h00, 8'h00, 1, 8'h01, 8'h00, 4'b0000);
        run_op("sbc0",     4'd9,  8'h00, 8'h00, 1, 8'h00, 8'h00, 4'b1000);
        run_op("sub_brw",  4'd1,  8'h00, 8'h01, 1, 8'hFF, 8'h00, 4'b0110);
        run_op("sbc1",     4'd9,  8'h05, 8'h02, 1, 8'h02, 8'h00, 4'b0000);
        run_op("sub_ovf",  4'd1,  8'h80, 8'h01, 1, 8'h7F, 8'h00, 4'b0001);
        run_op("xor",      4'd4,  8'hAA, 8'hFF, 1, 8'h55, 8'h00, 4'b0000);
        run_op("not",      4'd5,  8'h0F, 8'h00, 1, 8'hF0, 8'h00, 4'b0010);
        run_op("shl",      4'd6,  8'h81, 8'h00, 1, 8'h02, 8'h00, 4'b0100);
        run_op("shr",      4'd7,  8'h81, 8'h00, 1, 8'h40, 8'h00, 4'b0100);
        run_op("resv14",   4'd14, 8'h55, 8'h33, 1, 8'h00, 8'h00, 4'b1000);
        run_op("sran3",    4'd12, 8'h90, 8'h03, 4, 8'hF2, 8'h00, 4'b0010);
        run_op("slln0",    4'd10, 8'h81, 8'h00, 1, 8'h81, 8'h00, 4'b0010);
        run_op("slln1",    4'd10, 8'h81, 8'h01, 2, 8'h02, 8'h00, 4'b0100);
        run_op("srln7",    4'd11, 8'hC0, 8'h07, 8, 8'h01, 8'h00, 4'b0100);
        run_op("mul_ff",   4'd13, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 4'b0101);
        run_op("and",      4'd2,  8'hF0, 8'h3C, 1, 8'h30, 8'h00, 4'b0000);
        run_op("mul_small",4'd13, 8'h0F, 8'h11, 9, 8'hFF, 8'h00, 4'b0010);

        // Reset in the middle of a multiply: no completion may follow.
        bus.op       = 4'd13;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mid out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mid zcnv", flags_now(), 32'd0);
        check("rst_mid result", {24'd0, bus.result}, 32'd0);
        check("rst_mid result_hi", {24'd0, bus.result_hi}, 32'd0);
        ov_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid)
                ov_cnt++;
        end
        check("rst_mid no_out_valid", ov_cnt, 0);
        $display("txn rst_mid    mul aborted, out_valid pulses after reset=%0d", ov_cnt);

        run_op("add_post", 4'd0,  8'h02, 8'h03, 1, 8'h05, 8'h00, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
